uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit before STOP.
module uart_tx_mmio #(
  parameter int DIV_RESET  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic        a_tx, a_st, a_div;
  logic        tx_wr, st_clr, div_wr;
  logic        full, empty, busy;
  logic        push, pop;
  logic [15:0] reload;
  logic [15:0] div_new;
  logic [7:0]  head;
  logic        unused_bits;

  assign unused_bits = ^{wdata[31:16], wmask[3:2]};

  assign a_tx  = (addr == 4'h0);
  assign a_st  = (addr == 4'h4);
  assign a_div = (addr == 4'h8);

  assign tx_wr  = sel && a_tx && wmask[0] && !rst;
  assign st_clr = sel && a_st && wmask[0] && wdata[3];
  assign div_wr = sel && a_div && (wmask[1:0] != 2'b00);

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign busy  = (state_q != IDLE);
  assign irq   = empty && !busy;

  assign push   = tx_wr && !full;
  assign reload = div_q - 16'd1;
  assign head   = fifo_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  always_comb begin
    ovf_d = ovf_q;
    if (st_clr) ovf_d = 1'b0;
    if (tx_wr && full) ovf_d = 1'b1;
  end

  always_comb begin
    div_new = div_q;
    div_d   = div_q;
    if (div_wr) begin
      if (wmask[0]) div_new[7:0]  = wdata[7:0];
      if (wmask[1]) div_new[15:8] = wdata[15:8];
      div_d = (div_new == 16'd0) ? 16'd1 : div_new;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (sel && ren) begin
      unique case (1'b1)
        a_st:    rdata_d = {28'b0, ovf_q, busy, empty, full};
        a_div:   rdata_d = {16'b0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // Data bits rotate rather than shift, so after all 8 bits the
  // shifter holds the original byte again and ^shift_q is its parity.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = reload;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = reload;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = reload;
          idx_d   = idx_q + 3'd1;
          shift_d = {shift_q[0], shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PARITY: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = reload;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = reload;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = ^shift_q;
      default: tx = 1'b1;
    endcase
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 16'(DIV_RESET);
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= wdata[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench; a line receiver and a read
// monitor pop expected bytes/words queued by the stimulus.
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        ren;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  uart_tx_mmio #(.DIV_RESET(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr),
    .wdata(wdata), .wmask(wmask), .ren(ren),
    .rdata(rdata), .tx(tx), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int nstarts = 0;
  int aborts = 0;
  int mon_div = 16;
  int fstart [64];

  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic        rd_fire = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    rd_fire = sel && ren && !rst;
  end

  bit          rx_act = 1'b0;
  bit          rx_bad = 1'b0;
  int          rx_bit = 0;
  int          rx_cyc = 0;
  int          rx_badbit = 0;
  logic        rx_badval;
  logic [7:0]  rx_byte = 8'h00;
  logic [10:0] rx_exp = '1;

  initial forever begin
    @(negedge clk);
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected: got 0x%0h expected none", rdata);
      end else begin
        chk("rdata", rdata, rd_q.pop_front());
      end
    end
    if (rst) begin
      if (rx_act) aborts++;
      rx_act = 1'b0;
    end else begin
      if (!rx_act && tx === 1'b0) begin
        rx_act = 1'b1;
        rx_bit = 0;
        rx_cyc = 0;
        rx_bad = 1'b0;
        fstart[nstarts % 64] = cyc;
        nstarts++;
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: start at cycle %0d, expected none",
                   cyc);
          rx_exp = '1;
        end else begin
          rx_byte = tx_q.pop_front();
          rx_exp  = mk_frame(rx_byte);
        end
      end
      if (rx_act) begin
        if (tx !== rx_exp[rx_bit] && !rx_bad) begin
          rx_bad    = 1'b1;
          rx_badbit = rx_bit;
          rx_badval = tx;
        end
        rx_cyc++;
        if (rx_cyc == mon_div) begin
          rx_cyc = 0;
          rx_bit++;
          if (rx_bit == NB) begin
            rx_act = 1'b0;
            frames_done++;
            checks++;
            if (rx_bad) begin
              errors++;
              $display("FAIL frame_%0h: bit %0d got %b expected %b",
                       rx_byte, rx_badbit, rx_badval, rx_exp[rx_badbit]);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    sel   = 1'b1;
    ren   = 1'b0;
    addr  = a;
    wdata = d;
    wmask = m;
    tick();
    sel   = 1'b0;
    wmask = 4'b0000;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    sel   = 1'b1;
    ren   = 1'b1;
    addr  = a;
    wmask = 4'b0000;
    tick();
    sel = 1'b0;
    ren = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tx_q.push_back(b);
    wr(4'h0, {24'h0, b}, 4'b0001);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("frames_done", frames_done, n);
  endtask

  initial begin
    rst   = 1'b1;
    sel   = 1'b0;
    ren   = 1'b0;
    addr  = 4'h0;
    wdata = 32'h0;
    wmask = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_rdata", rdata, 32'h0);
    chk("reset_tx", {31'b0, tx}, 32'h1);
    chk("reset_irq", {31'b0, irq}, 32'h1);
    rd(4'h4, 32'h2);
    rd(4'h8, 32'd16);
    rd(4'h0, 32'h0);
    rd(4'hC, 32'h0);

    wr(4'h8, 32'd4, 4'b0011);
    mon_div = 4;
    rd(4'h8, 32'd4);
    send(8'h55);
    tick();
    tick();
    rd(4'h4, 32'h6);
    wait_frames(1);
    chk("irq_after_55", {31'b0, irq}, 32'h1);

    wr(4'h8, 32'd0, 4'b0011);
    rd(4'h8, 32'd1);
    wr(4'h8, 32'h1234_ABCD, 4'b0010);
    rd(4'h8, 32'h0000_AB01);

    wr(4'h8, 32'd4, 4'b0011);
    mon_div = 4;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    rd(4'h4, 32'h5);
    wr(4'h0, 32'h66, 4'b0001);
    rd(4'h4, 32'hD);
    wr(4'h4, 32'h8, 4'b0001);
    rd(4'h4, 32'h5);
    wait_frames(6);
    chk("irq_after_burst", {31'b0, irq}, 32'h1);
    rd(4'h4, 32'h2);

    wr(4'h8, 32'd3, 4'b0011);
    mon_div = 3;
    send(8'h3C);
    send(8'hC3);
    wait_frames(8);
    chk("b2b_gap", fstart[7] - fstart[6], NB * 3);

    wr(4'h8, 32'd2, 4'b0011);
    mon_div = 2;
    send(8'h07);
    send(8'h03);
    wait_frames(10);
    chk("par_gap", fstart[9] - fstart[8], NB * 2);

    wr(4'h8, 32'd4, 4'b0011);
    mon_div = 4;
    rd(4'h8, 32'd4);
    send(8'hA5);
    repeat (18) tick();
    rst   = 1'b1;
    sel   = 1'b1;
    addr  = 4'h0;
    wdata = 32'h99;
    wmask = 4'b0001;
    tick();
    chk("abort_tx", {31'b0, tx}, 32'h1);
    chk("abort_irq", {31'b0, irq}, 32'h1);
    chk("abort_rdata", rdata, 32'h0);
    rst   = 1'b0;
    sel   = 1'b0;
    wmask = 4'b0000;
    mon_div = 16;
    rd(4'h4, 32'h2);
    rd(4'h8, 32'd16);
    repeat (80) tick();
    chk("aborts", aborts, 1);
    chk("frame_starts", nstarts, 11);
    chk("tx_q_left", tx_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
